vram_slot_arbiter: RTL and testbench

//  Time-slot arbiter sharing the 128k video SRAM between C64 register writes and
//  the raster byte fetch. It runs a free 8-phase slot frame: phases 0-3 carry at

---
 rtl/vram_slot_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter for the shared video SRAM: an 8-phase frame with one queued
// C64 write in P0-P3 and one raster read in P4-P7. All state advances on negedge clk25.
module vram_slot_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                          clk25,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [2:0]                    phase,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          s_ce,
  output logic                          s_oe,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_dout,
  output logic                          s_drive,
  input  logic [DATA_W-1:0]             s_din
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3,
    P4 = 3'd4, P5 = 3'd5, P6 = 3'd6, P7 = 3'd7
  } phase_e;

  phase_e              phase_q, phase_d;

  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ready_q, ready_d;
  logic                ovf_q, ovf_d;
  logic                push, pop;

  logic                wr_act_q, wr_act_d;
  logic                rd_act_q, rd_act_d;

  logic                ce_q, ce_d;
  logic                oe_q, oe_d;
  logic                we_q, we_d;
  logic                drive_q, drive_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  // Strobes are computed for the phase being entered, so each case arm below
  // describes the bus state of the following phase.
  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    wr_act_d = wr_act_q;
    rd_act_d = rd_act_q;
    ce_d     = 1'b1;
    oe_d     = 1'b1;
    we_d     = 1'b1;
    drive_d  = 1'b0;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    pop      = 1'b0;

    case (phase_q)
      P7: begin
        if (rd_act_q) begin
          rdata_d  = s_din;
          rvalid_d = 1'b1;
        end
        rd_act_d = 1'b0;
        wr_act_d = 1'b0;
        if (count_q != '0) begin
          pop      = 1'b1;
          wr_act_d = 1'b1;
          addr_d   = fifo_addr_q[rd_ptr_q];
          dout_d   = fifo_data_q[rd_ptr_q];
          ce_d     = 1'b0;
          drive_d  = 1'b1;
        end
      end
      P0: begin
        if (wr_act_q) begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          drive_d = 1'b1;
        end
      end
      P1: begin
        if (wr_act_q) begin
          drive_d = 1'b1;
        end
      end
      P2: begin
        wr_act_d = 1'b0;
      end
      P3: begin
        if (rd_req) begin
          rd_act_d = 1'b1;
          addr_d   = rd_addr;
          ce_d     = 1'b0;
          oe_d     = 1'b0;
        end
      end
      P4, P5, P6: begin
        if (rd_act_q) begin
          ce_d = 1'b0;
          oe_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // A full queue stays closed even when the grant pops in the same cycle.
  always_comb begin
    push     = wr_valid & ready_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ready_d  = (count_d < CW'(FIFO_DEPTH));
    ovf_d    = ovf_q;
    if (wr_valid & ~ready_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(negedge clk25) begin
    if (rst) begin
      phase_q  <= P0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      drive_q  <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      wr_act_q <= wr_act_d;
      rd_act_q <= rd_act_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      drive_q  <= drive_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(negedge clk25) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready   = ready_q;
  assign rd_data    = rdata_q;
  assign rd_valid   = rvalid_q;
  assign phase      = phase_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign s_ce       = ce_q;
  assign s_oe       = oe_q;
  assign s_we       = we_q;
  assign s_drive    = drive_q;
  assign s_addr     = addr_q;
  assign s_dout     = dout_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Randomised bench for vram_slot_arbiter: a frame-level model (write queue, per-frame
// grants, phase table) checked every cycle, plus directed literal scenarios.
module tb_vram_slot_arbiter;

  localparam int DEPTH = 4;

  logic        clk25 = 1'b1;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [16:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  phase;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic        s_ce, s_oe, s_we, s_drive;
  logic [16:0] s_addr;
  logic [7:0]  s_dout;
  logic [7:0]  s_din = '0;

  vram_slot_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(17), .DATA_W(8)) dut (
    .clk25(clk25), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .phase(phase), .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr),
    .s_ce(s_ce), .s_oe(s_oe), .s_we(s_we), .s_addr(s_addr), .s_dout(s_dout),
    .s_drive(s_drive), .s_din(s_din)
  );

  always #20 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending writes, one write/read grant per frame.
  typedef struct { logic [16:0] a; logic [7:0] d; } wr_t;
  wr_t         mq[$];
  wr_t         m_w;
  bit          model_on = 0;
  int          m_ph = 0;
  bit          m_wv = 0, m_rv = 0, m_ovf = 0, m_rvalid = 0, m_rdy;
  logic [16:0] m_raddr = '0;
  logic [7:0]  m_rdata = '0;

  always @(negedge clk25) begin
    if (rst) begin
      m_ph = 0; mq.delete(); m_ovf = 0; m_wv = 0; m_rv = 0;
      m_rdata = '0; m_rvalid = 0; model_on = 1;
    end else if (model_on) begin
      m_rdy = (mq.size() < DEPTH);
      m_rvalid = 0;
      if (m_ph == 7) begin
        if (m_rv) begin m_rdata = s_din; m_rvalid = 1; end
        m_rv = 0;
        m_wv = (mq.size() > 0);
        if (m_wv) m_w = mq.pop_front();
      end
      if (m_ph == 3) begin
        m_rv = rd_req;
        if (rd_req) m_raddr = rd_addr;
      end
      if (wr_valid && m_rdy) mq.push_back('{wr_addr, wr_data});
      if (wr_valid && !m_rdy) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_ph = (m_ph + 1) % 8;
    end
  end

  bit e_ce, e_oe, e_we, e_dr;
  always @(posedge clk25) begin
    if (model_on) begin
      e_ce = 1; e_oe = 1; e_we = 1; e_dr = 0;
      case (m_ph)
        0: begin e_ce = !m_wv; e_dr = m_wv; end
        1: begin e_ce = !m_wv; e_we = !m_wv; e_dr = m_wv; end
        2: e_dr = m_wv;
        4, 5, 6, 7: begin e_ce = !m_rv; e_oe = !m_rv; end
        default: ;
      endcase
      chk("phase", 32'(phase), 32'(m_ph));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(m_rvalid));
      chk("rd_data", 32'(rd_data), 32'(m_rdata));
      chk("s_ce", 32'(s_ce), 32'(e_ce));
      chk("s_oe", 32'(s_oe), 32'(e_oe));
      chk("s_we", 32'(s_we), 32'(e_we));
      chk("s_drive", 32'(s_drive), 32'(e_dr));
      chk("contention", 32'(!s_oe && s_drive), 32'(0));
      if (m_ph <= 1 && m_wv) chk("s_addr_wr", 32'(s_addr), 32'(m_w.a));
      if (m_ph <= 2 && m_wv) chk("s_dout", 32'(s_dout), 32'(m_w.d));
      if (m_ph >= 4 && m_rv) chk("s_addr_rd", 32'(s_addr), 32'(m_raddr));
    end
  end

  task automatic tick();
    @(posedge clk25);
  endtask

  task automatic wait_phase(input int n);
    for (int i = 0; i < 16; i++) begin
      if (phase == 3'(n)) return;
      tick();
    end
    chk("wait_phase_timeout", 32'(phase), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int exp_ph;

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Single write of 1DE00/A5 pushed in P5
    wait_phase(5);
    wr_valid = 1; wr_addr = 17'h1DE00; wr_data = 8'hA5;
    tick();
    wr_valid = 0;
    chk("t2_count1", 32'(fifo_count), 32'd1);
    wait_phase(0);
    chk("t2_addr", 32'(s_addr), 32'h1DE00);
    chk("t2_dout", 32'(s_dout), 32'hA5);
    chk("t2_ce", 32'(s_ce), 32'd0);
    chk("t2_we_p0", 32'(s_we), 32'd1);
    chk("t2_count0", 32'(fifo_count), 32'd0);
    tick();
    chk("t2_we_p1", 32'(s_we), 32'd0);
    tick();
    chk("t2_we_p2", 32'(s_we), 32'd1);
    chk("t2_ce_p2", 32'(s_ce), 32'd1);
    chk("t2_drive_p2", 32'(s_drive), 32'd1);

    // Read of 00123 returning 3C
    wait_phase(3);
    rd_req = 1; rd_addr = 17'h00123;
    tick();
    rd_req = 0;
    chk("t3_addr", 32'(s_addr), 32'h00123);
    chk("t3_oe", 32'(s_oe), 32'd0);
    wait_phase(7);
    s_din = 8'h3C;
    tick();
    chk("t3_rdata", 32'(rd_data), 32'h3C);
    chk("t3_rvalid", 32'(rd_valid), 32'd1);
    tick();
    chk("t3_rvalid_off", 32'(rd_valid), 32'd0);

    // Five pushes P1-P5 into a depth-4 queue
    wait_phase(1);
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1; wr_addr = 17'(17'h10000 + k); wr_data = 8'(8'h50 + k);
      if (k == 4) chk("t4_ready0", 32'(wr_ready), 32'd0);
      tick();
    end
    wr_valid = 0;
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      wait_phase(0);
      chk("t4_drain_addr", 32'(s_addr), 32'(17'h10000 + k));
      chk("t4_drain_data", 32'(s_dout), 32'(8'h50 + k));
      tick();
    end
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // Idle: no requests for 16 cycles
    wait_phase(6);
    tick(); tick();
    exp_ph = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t6_phase", 32'(phase), 32'(exp_ph));
      chk("t6_strobes", 32'({s_ce, s_oe, s_we}), 32'h7);
      chk("t6_rvalid", 32'(rd_valid), 32'd0);
      exp_ph = (exp_ph + 1) % 8;
      tick();
    end

    // Concurrent write + read every frame for 64 frames
    for (int f = 0; f < 64; f++) begin
      wait_phase(3);
      rd_req = 1; rd_addr = 17'($urandom());
      tick();
      rd_req = 0;
      chk("t5_rd_ce", 32'(s_ce), 32'd0);
      tick();
      wr_valid = 1; wr_addr = 17'($urandom()); wr_data = 8'($urandom());
      tick();
      wr_valid = 0;
      s_din = 8'($urandom());
      wait_phase(1);
      chk("t5_we", 32'(s_we), 32'd0);
    end

    // Reset held 2 cycles while a write sits in P1
    wait_phase(1);
    chk("t1_we_before", 32'(s_we), 32'd0);
    rst = 1;
    tick();
    chk("t1_strobes", 32'({s_ce, s_we, s_oe}), 32'h7);
    chk("t1_drive", 32'(s_drive), 32'd0);
    chk("t1_phase", 32'(phase), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd0);
    chk("t1_addr", 32'(s_addr), 32'd0);
    tick();
    rst = 0;

    // Random traffic including sporadic reset and overflow clears
    for (int i = 0; i < 1200; i++) begin
      wr_valid = ($urandom_range(0, 99) < 35);
      wr_addr  = 17'($urandom());
      wr_data  = 8'($urandom());
      rd_req   = ($urandom_range(0, 99) < 60);
      rd_addr  = 17'($urandom());
      ovf_clr  = ($urandom_range(0, 99) < 5);
      s_din    = 8'($urandom());
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    wr_valid = 0; rd_req = 0; ovf_clr = 0; rst = 0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
